mdu_iter: RTL and testbench

- Iterative multiply/divide unit for the RV32IM build; consumes the md_op control and MDU opcode produced by the instruction controller.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU over multiple cycles.
- Valid/ready on both sides lets the execute stage stall while the unit is busy.

---
 rtl/mdu_iter_if.sv | 34 +++
 rtl/mdu_iter.sv | 174 +++++++++++++++++
 tb/tb_mdu_iter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_if
// Description : Request/result handshake bundle between execute stage and MDU.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_iter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int MDU_OP_WIDTH = 3
);
  logic                    start_i;
  logic [MDU_OP_WIDTH-1:0] op_i;
  logic [DATA_WIDTH-1:0]   operand_a_i;
  logic [DATA_WIDTH-1:0]   operand_b_i;
  logic                    flush_i;
  logic                    ready_o;
  logic                    busy_o;
  logic [DATA_WIDTH-1:0]   result_o;
  logic                    result_valid_o;
  logic                    result_ready_i;

  // Controller side
  modport master (
    output start_i, op_i, operand_a_i, operand_b_i, flush_i, result_ready_i,
    input  ready_o, busy_o, result_o, result_valid_o
  );

  // Multiply/divide unit side
  modport slave (
    input  start_i, op_i, operand_a_i, operand_b_i, flush_i, result_ready_i,
    output ready_o, busy_o, result_o, result_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative RV32M multiply/divide unit (shift-add / restoring).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MDU_OP_WIDTH = 3
) (
  input  logic      clk_i,
  input  logic      rst_i,
  mdu_iter_if.slave mdu
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [MDU_OP_WIDTH-1:0] OP_MUL    = MDU_OP_WIDTH'(0);
  localparam logic [MDU_OP_WIDTH-1:0] OP_MULH   = MDU_OP_WIDTH'(1);
  localparam logic [MDU_OP_WIDTH-1:0] OP_MULHSU = MDU_OP_WIDTH'(2);
  localparam logic [MDU_OP_WIDTH-1:0] OP_DIV    = MDU_OP_WIDTH'(4);
  localparam logic [MDU_OP_WIDTH-1:0] OP_REM    = MDU_OP_WIDTH'(6);

  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [MDU_OP_WIDTH-1:0] op_q, op_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*W-1:0]          acc_q, acc_d;
  logic [W-1:0]            opb_q, opb_d;
  logic                    neg_q, neg_d;
  logic [W-1:0]            result_q, result_d;
  logic                    valid_q, valid_d;

  logic           is_div, a_signed, b_signed, sign_a, sign_b;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [2*W-1:0] mul_next, div_next, mul_fix;
  logic [W-1:0]   div_rem, div_sel, div_fix, fix_result;

  always_comb begin
    is_div   = mdu.op_i[MDU_OP_WIDTH-1];
    a_signed = (mdu.op_i == OP_MUL) || (mdu.op_i == OP_MULH) || (mdu.op_i == OP_MULHSU) ||
               (mdu.op_i == OP_DIV) || (mdu.op_i == OP_REM);
    b_signed = (mdu.op_i == OP_MUL) || (mdu.op_i == OP_MULH) ||
               (mdu.op_i == OP_DIV) || (mdu.op_i == OP_REM);
    sign_a   = a_signed & mdu.operand_a_i[W-1];
    sign_b   = b_signed & mdu.operand_b_i[W-1];
    a_mag    = sign_a ? -mdu.operand_a_i : mdu.operand_a_i;
    b_mag    = sign_b ? -mdu.operand_b_i : mdu.operand_b_i;

    // Multiply: acc = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opb_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

    // Divide: acc = {remainder, dividend shifting into quotient}
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_rem   = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
    div_next  = {div_rem, acc_q[W-2:0], ~div_diff[W]};

    mul_fix    = neg_q ? -acc_q : acc_q;
    div_sel    = op_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];
    div_fix    = neg_q ? -div_sel : div_sel;
    fix_result = op_q[MDU_OP_WIDTH-1] ? div_fix :
                 (op_q == OP_MUL)     ? mul_fix[W-1:0] : mul_fix[2*W-1:W];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    result_d = result_q;
    valid_d  = valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (mdu.start_i && !mdu.flush_i) begin
          op_d  = mdu.op_i;
          neg_d = (is_div && mdu.op_i[1]) ? sign_a : (sign_a ^ sign_b);
          cnt_d = '1;
          if (is_div) begin
            acc_d = {{W{1'b0}}, a_mag};
            opb_d = b_mag;
          end else begin
            acc_d = {{W{1'b0}}, b_mag};
            opb_d = a_mag;
          end
          // Divide-by-zero and signed overflow bypass the iteration entirely
          if (is_div && (mdu.operand_b_i == '0)) begin
            result_d = mdu.op_i[1] ? mdu.operand_a_i : '1;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else if (((mdu.op_i == OP_DIV) || (mdu.op_i == OP_REM)) &&
                       (mdu.operand_a_i == MIN_INT) && (mdu.operand_b_i == '1)) begin
            result_d = mdu.op_i[1] ? '0 : MIN_INT;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (mdu.flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[MDU_OP_WIDTH-1] ? div_next : mul_next;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_FIX: begin
        if (mdu.flush_i) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_result;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (mdu.flush_i || mdu.result_ready_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign mdu.ready_o        = (state_q == S_IDLE);
  assign mdu.busy_o         = (state_q != S_IDLE);
  assign mdu.result_o       = result_q;
  assign mdu.result_valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_iter
// Description : Directed self-checking bench for the iterative MDU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mdu_iter_if #(.DATA_WIDTH(32), .MDU_OP_WIDTH(3)) mdu_bus ();

  mdu_iter #(.DATA_WIDTH(32), .MDU_OP_WIDTH(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .mdu   (mdu_bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency, optionally stall the consumer, then retire it.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int   cyc;
    logic saw_ready, stable;
    check({tag, "_rdy_pre"}, {31'b0, mdu_bus.ready_o}, 32'd1);
    mdu_bus.start_i     = 1'b1;
    mdu_bus.op_i        = op;
    mdu_bus.operand_a_i = a;
    mdu_bus.operand_b_i = b;
    @(posedge clk); #1;
    mdu_bus.start_i     = 1'b0;
    mdu_bus.operand_a_i = 32'hDEAD_BEEF;
    mdu_bus.operand_b_i = 32'h1234_5678;
    mdu_bus.op_i        = 3'd7 - op;
    cyc       = 1;
    saw_ready = 1'b0;
    while (!mdu_bus.result_valid_o && cyc < 100) begin
      saw_ready |= mdu_bus.ready_o;
      @(posedge clk); #1;
      cyc++;
    end
    saw_ready |= mdu_bus.ready_o;
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_res"}, mdu_bus.result_o, exp);
    check({tag, "_rdy_low"}, {31'b0, saw_ready}, 32'd0);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (mdu_bus.result_o !== exp || mdu_bus.result_valid_o !== 1'b1) stable = 1'b0;
      end
      check({tag, "_hold"}, {31'b0, stable}, 32'd1);
    end
    mdu_bus.result_ready_i = 1'b1;
    @(posedge clk); #1;
    mdu_bus.result_ready_i = 1'b0;
    check({tag, "_vdrop"}, {31'b0, mdu_bus.result_valid_o}, 32'd0);
    check({tag, "_rdy_post"}, {31'b0, mdu_bus.ready_o}, 32'd1);
    check({tag, "_keep"}, mdu_bus.result_o, exp);
  endtask

  initial begin
    logic saw_valid;
    mdu_bus.start_i        = 1'b0;
    mdu_bus.op_i           = 3'd0;
    mdu_bus.operand_a_i    = '0;
    mdu_bus.operand_b_i    = '0;
    mdu_bus.flush_i        = 1'b0;
    mdu_bus.result_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ready",  {31'b0, mdu_bus.ready_o},        32'd1);
    check("reset_busy",   {31'b0, mdu_bus.busy_o},         32'd0);
    check("reset_valid",  {31'b0, mdu_bus.result_valid_o}, 32'd0);
    check("reset_result", mdu_bus.result_o,                32'd0);

    // Normal path: 34-cycle latency
    run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("divu",   3'd5, 32'd100,       32'd7,         32'd14,        34, 0);
    run_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         34, 10);

    // Special cases: result one cycle after accept
    run_op("divu_z", 3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op("rem_z",  3'd6, 32'd5,         32'd0,         32'd5,         1, 0);
    run_op("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 3);

    // Flush mid-divide
    mdu_bus.start_i     = 1'b1;
    mdu_bus.op_i        = 3'd4;
    mdu_bus.operand_a_i = 32'd1000;
    mdu_bus.operand_b_i = 32'd3;
    @(posedge clk); #1;
    mdu_bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 mdu_bus.flush_i = 1'b1;
    @(posedge clk); #1;
    mdu_bus.flush_i = 1'b0;
    check("flush_ready", {31'b0, mdu_bus.ready_o}, 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      saw_valid |= mdu_bus.result_valid_o;
      @(posedge clk); #1;
    end
    check("flush_novalid", {31'b0, saw_valid}, 32'd0);
    run_op("mul_after", 3'd0, 32'd3, 32'd4, 32'd12, 34, 0);

    // Flush in IDLE blocks acceptance
    mdu_bus.start_i = 1'b1;
    mdu_bus.flush_i = 1'b1;
    @(posedge clk); #1;
    mdu_bus.start_i = 1'b0;
    mdu_bus.flush_i = 1'b0;
    check("flush_idle_busy", {31'b0, mdu_bus.busy_o}, 32'd0);

    // Asynchronous reset mid-CALC
    mdu_bus.start_i     = 1'b1;
    mdu_bus.op_i        = 3'd0;
    mdu_bus.operand_a_i = 32'd9;
    mdu_bus.operand_b_i = 32'd9;
    @(posedge clk); #1;
    mdu_bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready",  {31'b0, mdu_bus.ready_o},        32'd1);
    check("arst_busy",   {31'b0, mdu_bus.busy_o},         32'd0);
    check("arst_valid",  {31'b0, mdu_bus.result_valid_o}, 32'd0);
    check("arst_result", mdu_bus.result_o,                32'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_op("mul_post_rst", 3'd0, 32'd6, 32'd7, 32'd42, 34, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
